sound_seq: RTL and testbench

SOUND_SEQ -- requirements
Module: sound_seq

---
 rtl/sound_seq.sv | 156 +++++++++++++++
 tb/tb_sound_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sound_seq.sv
// Multi-channel beep sequencer: the highest-index trigger wins, and a tone/gap burst
// plays on one registered square-wave output.
//
// state  | meaning
// IDLE   | no sequence; speaker low, active_ch 0
// TONE   | square wave running for one DUR window
// GAP    | silent DUR window between beeps
module sound_seq #(
  parameter int                      NUM_CH   = 4,
  parameter int                      DIV_W    = 16,
  parameter int                      DUR_W    = 24,
  parameter logic [NUM_CH*DIV_W-1:0] HALF_PER = {NUM_CH{DIV_W'(2)}},
  parameter logic [NUM_CH*DUR_W-1:0] DUR      = {NUM_CH{DUR_W'(1000)}},
  parameter logic [NUM_CH*4-1:0]     REPS     = {NUM_CH{4'd1}},
  localparam int                     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] trigger,
  input  logic              mute,
  output logic              speaker,
  output logic              busy,
  output logic [CH_W-1:0]   active_ch,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TONE = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state, state_nx;
  logic [DIV_W-1:0] div_cnt, div_nx;
  logic [DUR_W-1:0] dur_cnt, dur_nx;
  logic [3:0]       reps_left, reps_nx;
  logic             tone, tone_nx;
  logic [CH_W-1:0]  ch_nx;
  logic             done_nx;

  logic [DIV_W-1:0] hp_last  [NUM_CH];
  logic [DUR_W-1:0] dur_last [NUM_CH];
  logic [3:0]       reps_tab [NUM_CH];

  // Zero-valued parameters behave as 1; store terminal counts directly.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_tab
    localparam logic [DIV_W-1:0] HP_RAW  = HALF_PER[g*DIV_W +: DIV_W];
    localparam logic [DUR_W-1:0] DUR_RAW = DUR[g*DUR_W +: DUR_W];
    localparam logic [3:0]       REP_RAW = REPS[g*4 +: 4];
    assign hp_last[g]  = (HP_RAW  == '0) ? '0 : HP_RAW - DIV_W'(1);
    assign dur_last[g] = (DUR_RAW == '0) ? '0 : DUR_RAW - DUR_W'(1);
    assign reps_tab[g] = (REP_RAW == '0) ? 4'd1 : REP_RAW;
  end

  logic [CH_W-1:0] winner;
  logic            trig_any;
  logic            accept;

  always_comb begin
    winner   = '0;
    trig_any = |trigger;
    for (int i = 0; i < NUM_CH; i++) begin
      if (trigger[i]) winner = CH_W'(i);
    end
  end

  // Equal or higher index restarts the sequence; lower requests are dropped.
  assign accept = trig_any && ((state == S_IDLE) || (winner >= active_ch));

  always_comb begin
    state_nx = state;
    ch_nx    = active_ch;
    div_nx   = div_cnt;
    dur_nx   = dur_cnt;
    reps_nx  = reps_left;
    tone_nx  = tone;
    done_nx  = 1'b0;
    if (accept) begin
      state_nx = S_TONE;
      ch_nx    = winner;
      div_nx   = '0;
      dur_nx   = '0;
      reps_nx  = reps_tab[winner];
      tone_nx  = 1'b0;
    end else begin
      case (state)
        S_TONE: begin
          if (dur_cnt == dur_last[active_ch]) begin
            div_nx  = '0;
            dur_nx  = '0;
            tone_nx = 1'b0;
            if (reps_left > 4'd1) begin
              state_nx = S_GAP;
              reps_nx  = reps_left - 4'd1;
            end else begin
              state_nx = S_IDLE;
              ch_nx    = '0;
              reps_nx  = '0;
              done_nx  = 1'b1;
            end
          end else begin
            dur_nx = dur_cnt + DUR_W'(1);
            if (div_cnt == hp_last[active_ch]) begin
              div_nx  = '0;
              tone_nx = ~tone;
            end else begin
              div_nx = div_cnt + DIV_W'(1);
            end
          end
        end
        S_GAP: begin
          div_nx  = '0;
          tone_nx = 1'b0;
          if (dur_cnt == dur_last[active_ch]) begin
            state_nx = S_TONE;
            dur_nx   = '0;
          end else begin
            dur_nx = dur_cnt + DUR_W'(1);
          end
        end
        default: begin
          state_nx = S_IDLE;
          ch_nx    = '0;
          div_nx   = '0;
          dur_nx   = '0;
          reps_nx  = '0;
          tone_nx  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      active_ch <= '0;
      div_cnt   <= '0;
      dur_cnt   <= '0;
      reps_left <= '0;
      tone      <= 1'b0;
      speaker   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      active_ch <= ch_nx;
      div_cnt   <= div_nx;
      dur_cnt   <= dur_nx;
      reps_left <= reps_nx;
      tone      <= tone_nx;
      // Mute only masks the pin; the tone phase keeps running underneath.
      speaker   <= tone_nx & ~mute;
      done      <= done_nx;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_sound_seq.sv
// Directed bench for sound_seq: the stimulus queues the expected per-sequence results,
// and a negedge monitor checks them against each done pulse.
module tb_sound_seq;

  logic       clk;
  logic       rst;
  logic [3:0] trigger;
  logic       mute;
  logic       speaker;
  logic       busy;
  logic [1:0] active_ch;
  logic       done;

  // ch0: HP2 DUR8 R1, ch1: HP1 DUR4 R3, ch2: HP3 DUR6 R2, ch3: all zero
  sound_seq #(
    .NUM_CH  (4),
    .DIV_W   (16),
    .DUR_W   (24),
    .HALF_PER({16'd0, 16'd3, 16'd1, 16'd2}),
    .DUR     ({24'd0, 24'd6, 24'd4, 24'd8}),
    .REPS    ({4'd0, 4'd2, 4'd3, 4'd1})
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .trigger  (trigger),
    .mute     (mute),
    .speaker  (speaker),
    .busy     (busy),
    .active_ch(active_ch),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    int          ch;
    int          len;
    logic [63:0] spk;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input string name, input int ch, input int len, input logic [63:0] spk);
    exp_t e;
    e.name = name;
    e.ch   = ch;
    e.len  = len;
    e.spk  = spk;
    exp_q.push_back(e);
  endtask

  // Monitor: collects one busy window (speaker per cycle, last channel, length)
  // and pops the expectation when done appears.
  logic        prev_busy = 1'b0;
  int          obs_len   = 0;
  int          obs_ch    = 0;
  logic [63:0] obs_spk   = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        if (!prev_busy) begin
          obs_len = 0;
          obs_spk = '0;
        end
        if (obs_len < 64) obs_spk[obs_len] = speaker;
        obs_ch = int'(active_ch);
        obs_len++;
      end
      prev_busy = busy;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected none at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_ch"},  obs_ch,  e.ch);
          check({e.name, "_len"}, obs_len, e.len);
          check({e.name, "_spk"}, obs_spk, e.spk);
          check({e.name, "_busy_at_done"}, busy, 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] mask);
    trigger = mask;
    tick(1);
    trigger = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=1 expected 0 after %0d cycles", n);
    end
    tick(3);
  endtask

  initial begin
    rst     = 1'b1;
    trigger = '0;
    mute    = 1'b0;
    tick(3);
    check("rst_speaker", speaker, 0);
    check("rst_busy", busy, 0);
    check("rst_active_ch", active_ch, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick(2);

    // Single beep on ch0: toggles at cycles 2,4,6, busy for 8 cycles.
    push_exp("ch0_basic", 0, 8, 64'hCC);
    pulse(4'b0001);
    wait_idle();

    // ch1: three tones of 4 cycles separated by gaps, toggling every cycle.
    push_exp("ch1_reps", 1, 20, 64'hA0A0A);
    pulse(4'b0010);
    wait_idle();

    // ch2 preempts ch0 at cycle 3; a later ch1 request is ignored.
    push_exp("preempt", 2, 21, 64'h1C01C4);
    pulse(4'b0001);
    tick(2);
    pulse(4'b0100);
    tick(4);
    pulse(4'b0010);
    wait_idle();

    // Two triggers resolve to ch2; mute silences the pin only.
    push_exp("mute_0110", 2, 18, 64'h0);
    mute = 1'b1;
    pulse(4'b0110);
    wait_idle();
    mute = 1'b0;

    // Async reset mid-tone aborts with no done.
    pulse(4'b0010);
    tick(1);
    check("pre_rst_speaker", speaker, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_speaker", speaker, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_active_ch", active_ch, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    push_exp("after_rst", 1, 20, 64'hA0A0A);
    pulse(4'b0010);
    wait_idle();

    // Zero parameters on ch3 act as a single 1-cycle beep.
    push_exp("ch3_zero", 3, 1, 64'h0);
    pulse(4'b1000);
    wait_idle();

    // Held trigger restarts every cycle for 5 edges.
    push_exp("hold_retrig", 0, 12, 64'hCC0);
    trigger = 4'b0001;
    tick(5);
    trigger = '0;
    wait_idle();

    // Retrigger on the completion edge suppresses that done.
    push_exp("end_retrig", 0, 16, 64'hCCCC);
    pulse(4'b0001);
    tick(7);
    pulse(4'b0001);
    wait_idle();

    check("pending_expectations", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
